// File: rtl/nvio_ipt_ctl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nvio_ipt_ctl
// Sequencer for the NVIO inverted-page-table MMU register port. A single-cycle
// request (update / probe / readback of one PTE) becomes a series of bus
// accesses on the MMU register slave: PTE and VPN register writes, a command
// write, a settle wait for the hash-chain walk, then PTE and VPN register reads.
//
// Optional feature macro: IPT_CTL_TIMEOUT_EN
//   defined   : each bus access aborts after ACK_TIMEOUT cycles without ack_i;
//               the sequence jumps to completion with err_o=1.
//   undefined : accesses wait for ack_i indefinitely; err_o is tied low.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_i, op_i       request strobe (taken only while idle), op 01/10/11/00
//   asid_i, vpn_i, key_i, drwx_i, last_i   PTE fields of the request
//   busy_o, done_o    request in progress, one-cycle completion pulse
//   err_o, hit_o      completion status (bus timeout, readback rwx non-zero)
//   res_*_o           fields from the last PTE/VPN readback, held
//   cyc_o, stb_o, we_o, sel_o, adr_o, dat_o   bus initiator outputs
//   ack_i, dat_i      bus response
// -----------------------------------------------------------------------------
module nvio_ipt_ctl #(
    parameter logic [31:0] IPT_BASE    = 32'hFFDC_0000,
    parameter int          SETTLE_CYC  = 8
`ifdef IPT_CTL_TIMEOUT_EN
    ,
    parameter int          ACK_TIMEOUT = 255
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [1:0]  op_i,
    input  logic [7:0]  asid_i,
    input  logic [18:0] vpn_i,
    input  logic [9:0]  key_i,
    input  logic [3:0]  drwx_i,
    input  logic        last_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        hit_o,
    output logic [9:0]  res_key_o,
    output logic [7:0]  res_asid_o,
    output logic        res_last_o,
    output logic [3:0]  res_drwx_o,
    output logic [18:0] res_vpn_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [15:0] sel_o,
    output logic [31:0] adr_o,
    output logic [63:0] dat_o,
    input  logic        ack_i,
    input  logic [63:0] dat_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_PTE = 3'd1,
        S_WR_VPN = 3'd2,
        S_WR_CMD = 3'd3,
        S_SETTLE = 3'd4,
        S_RD_PTE = 3'd5,
        S_RD_VPN = 3'd6,
        S_DONE   = 3'd7
    } state_e;

    localparam logic [31:0] ADR_CMD = IPT_BASE;
    localparam logic [31:0] ADR_PTE = IPT_BASE + 32'h0000_0010;
    localparam logic [31:0] ADR_VPN = IPT_BASE + 32'h0000_0018;
    localparam logic [15:0] SEL_ON  = 16'h00FF;

    // Write image of the PTE register; the write port places 'last' at bit 22.
    function automatic logic [63:0] pack_pte(input logic [9:0] key,
                                             input logic [7:0] asid,
                                             input logic       last,
                                             input logic [3:0] drwx);
        return {22'd0, key, asid, 1'b0, last, 14'd0, drwx[3], 4'd0, drwx[2:0]};
    endfunction

    function automatic logic [31:0] acc_adr(input state_e st);
        case (st)
            S_WR_PTE, S_RD_PTE: return ADR_PTE;
            S_WR_VPN, S_RD_VPN: return ADR_VPN;
            default:            return ADR_CMD;
        endcase
    endfunction

    function automatic logic acc_we(input state_e st);
        case (st)
            S_WR_PTE, S_WR_VPN, S_WR_CMD: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] acc_dat(input state_e      st,
                                            input logic [1:0]  op,
                                            input logic [9:0]  key,
                                            input logic [7:0]  asid,
                                            input logic        last,
                                            input logic [3:0]  drwx,
                                            input logic [18:0] vpn);
        case (st)
            S_WR_PTE: return pack_pte(key, asid, last, drwx);
            S_WR_VPN: return {45'd0, vpn};
            S_WR_CMD: return (op == 2'b01) ? 64'h1 : 64'h2;
            default:  return 64'h0;
        endcase
    endfunction

    // Sequence step taken once the current access has been acknowledged.
    function automatic state_e after_ack(input state_e st);
        case (st)
            S_WR_PTE: return S_WR_VPN;
            S_WR_VPN: return S_WR_CMD;
            S_WR_CMD: return S_SETTLE;
            S_RD_PTE: return S_RD_VPN;
            default:  return S_DONE;
        endcase
    endfunction

    state_e      state_q;
    logic [1:0]  op_q;
    logic [7:0]  asid_q;
    logic [18:0] vpn_q;
    logic [9:0]  key_q;
    logic [3:0]  drwx_q;
    logic        last_q;
    logic [7:0]  set_cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        hit_q;
    logic [9:0]  res_key_q;
    logic [7:0]  res_asid_q;
    logic        res_last_q;
    logic [3:0]  res_drwx_q;
    logic [18:0] res_vpn_q;
    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [15:0] sel_q;
    logic [31:0] adr_q;
    logic [63:0] dat_q;
`ifdef IPT_CTL_TIMEOUT_EN
    logic [7:0]  to_cnt_q;
    logic        err_flag_q;
    logic        err_q;
`endif

    // Request sequencer: state, latched request, bus outputs and results.
    // Accesses after the first are entered with cyc low and raised one edge
    // later, which yields the mandatory idle cycle between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 2'd0;
            asid_q     <= 8'd0;
            vpn_q      <= 19'd0;
            key_q      <= 10'd0;
            drwx_q     <= 4'd0;
            last_q     <= 1'b0;
            set_cnt_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            res_key_q  <= 10'd0;
            res_asid_q <= 8'd0;
            res_last_q <= 1'b0;
            res_drwx_q <= 4'd0;
            res_vpn_q  <= 19'd0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 16'd0;
            adr_q      <= 32'd0;
            dat_q      <= 64'd0;
`ifdef IPT_CTL_TIMEOUT_EN
            to_cnt_q   <= 8'd0;
            err_flag_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef IPT_CTL_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        op_q   <= op_i;
                        asid_q <= asid_i;
                        vpn_q  <= vpn_i;
                        key_q  <= key_i;
                        drwx_q <= drwx_i;
                        last_q <= last_i;
                        busy_q <= 1'b1;
                        case (op_i)
                            2'b01, 2'b10: begin
                                state_q <= S_WR_PTE;
                                cyc_q   <= 1'b1;
                                stb_q   <= 1'b1;
                                we_q    <= 1'b1;
                                sel_q   <= SEL_ON;
                                adr_q   <= ADR_PTE;
                                dat_q   <= pack_pte(key_i, asid_i, last_i, drwx_i);
                            end
                            2'b11: begin
                                state_q <= S_RD_PTE;
                                cyc_q   <= 1'b1;
                                stb_q   <= 1'b1;
                                we_q    <= 1'b0;
                                sel_q   <= SEL_ON;
                                adr_q   <= ADR_PTE;
                                dat_q   <= 64'd0;
                            end
                            default: begin
                                state_q <= S_DONE;
                            end
                        endcase
`ifdef IPT_CTL_TIMEOUT_EN
                        to_cnt_q <= 8'd0;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_WR_PTE, S_WR_VPN, S_WR_CMD, S_RD_PTE, S_RD_VPN: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        we_q  <= acc_we(state_q);
                        sel_q <= SEL_ON;
                        adr_q <= acc_adr(state_q);
                        dat_q <= acc_dat(state_q, op_q, key_q, asid_q, last_q,
                                         drwx_q, vpn_q);
`ifdef IPT_CTL_TIMEOUT_EN
                        to_cnt_q <= 8'd0;
`endif
                    end else if (ack_i) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        we_q      <= 1'b0;
                        sel_q     <= 16'd0;
                        adr_q     <= 32'd0;
                        dat_q     <= 64'd0;
                        set_cnt_q <= 8'd0;
                        state_q   <= after_ack(state_q);
                        if (state_q == S_RD_PTE) begin
                            // Read port carries 'last' at bit 23, not 22.
                            res_key_q  <= dat_i[41:32];
                            res_asid_q <= dat_i[31:24];
                            res_last_q <= dat_i[23];
                            res_drwx_q <= {dat_i[7], dat_i[2:0]};
                            hit_q      <= |dat_i[2:0];
                        end else if (state_q == S_RD_VPN) begin
                            res_vpn_q <= dat_i[18:0];
                        end else begin
                            res_vpn_q <= res_vpn_q;
                        end
                    end
`ifdef IPT_CTL_TIMEOUT_EN
                    else if (to_cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        sel_q      <= 16'd0;
                        adr_q      <= 32'd0;
                        dat_q      <= 64'd0;
                        err_flag_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
`else
                    else begin
                        state_q <= state_q;
                    end
`endif
                end

                // Quiet window for the MMU's hash-chain walk after a command.
                S_SETTLE: begin
                    if (set_cnt_q == 8'(SETTLE_CYC - 1)) begin
                        set_cnt_q <= 8'd0;
                        state_q   <= (op_q == 2'b10) ? S_RD_PTE : S_DONE;
                    end else begin
                        set_cnt_q <= set_cnt_q + 8'd1;
                    end
                end

                // Completion: done_o rises together with busy_o falling, and
                // the controller is back in IDLE so it can accept in that cycle.
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
`ifdef IPT_CTL_TIMEOUT_EN
                    err_q      <= err_flag_q;
                    err_flag_q <= 1'b0;
`endif
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Response bits with no meaning in either readback register.
    logic unused_s;
    assign unused_s = ^{dat_i[63:42], dat_i[22:19]};

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign hit_o      = hit_q;
    assign res_key_o  = res_key_q;
    assign res_asid_o = res_asid_q;
    assign res_last_o = res_last_q;
    assign res_drwx_o = res_drwx_q;
    assign res_vpn_o  = res_vpn_q;
    assign cyc_o      = cyc_q;
    assign stb_o      = stb_q;
    assign we_o       = we_q;
    assign sel_o      = sel_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
`ifdef IPT_CTL_TIMEOUT_EN
    assign err_o      = err_q;
`else
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_nvio_ipt_ctl.sv
`timescale 1ns/1ps
module tb_nvio_ipt_ctl;

    localparam logic [31:0] BASE   = 32'hFFDC_0000;
    localparam int          SETTLE = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [1:0]  op_i;
    logic [7:0]  asid_i;
    logic [18:0] vpn_i;
    logic [9:0]  key_i;
    logic [3:0]  drwx_i;
    logic        last_i;
    logic        busy_o, done_o, err_o, hit_o;
    logic [9:0]  res_key_o;
    logic [7:0]  res_asid_o;
    logic        res_last_o;
    logic [3:0]  res_drwx_o;
    logic [18:0] res_vpn_o;
    logic        cyc_o, stb_o, we_o;
    logic [15:0] sel_o;
    logic [31:0] adr_o;
    logic [63:0] dat_o;
    logic        ack_i = 1'b0;
    logic [63:0] dat_i = 64'd0;

    always #5 clk = ~clk;

    nvio_ipt_ctl #(
        .IPT_BASE   (BASE),
        .SETTLE_CYC (SETTLE)
`ifdef IPT_CTL_TIMEOUT_EN
        ,
        .ACK_TIMEOUT(4)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i),
        .asid_i(asid_i), .vpn_i(vpn_i), .key_i(key_i), .drwx_i(drwx_i), .last_i(last_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .hit_o(hit_o),
        .res_key_o(res_key_o), .res_asid_o(res_asid_o), .res_last_o(res_last_o),
        .res_drwx_o(res_drwx_o), .res_vpn_o(res_vpn_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
        .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- bus responder (acks one cycle after sampling stb) -------
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [63:0] dat;
    } acc_t;

    acc_t        bus_log[$];
    acc_t        exp_log[$];
    logic [63:0] rsp_pte = 64'd0;
    logic [63:0] rsp_vpn = 64'd0;
    logic        stall_en = 1'b0;
    logic [31:0] stall_adr = 32'd0;
    int          sel_bad = 0;

    always @(posedge clk) begin
        if (cyc_o && stb_o && !ack_i && !(stall_en && adr_o == stall_adr)) begin
            ack_i <= 1'b1;
            bus_log.push_back('{we: we_o, adr: adr_o, dat: (we_o ? dat_o : 64'd0)});
            if (sel_o != 16'h00FF) sel_bad = sel_bad + 1;
            if (adr_o == BASE + 32'h10)      dat_i <= rsp_pte;
            else if (adr_o == BASE + 32'h18) dat_i <= rsp_vpn;
            else                             dat_i <= 64'd0;
        end else begin
            ack_i <= 1'b0;
            dat_i <= {$urandom, $urandom};
        end
    end

    // ---------------- behavioural reference model ------------------------------
    logic [9:0]  m_key;
    logic [7:0]  m_asid;
    logic        m_last;
    logic [3:0]  m_drwx;
    logic [18:0] m_vpn;

    task automatic model_reset();
        m_key = 10'd0; m_asid = 8'd0; m_last = 1'b0; m_drwx = 4'd0; m_vpn = 19'd0;
    endtask

    // Builds the expected access list and completion latency for one request
    // and advances the model's result registers.
    task automatic model_req(input logic [1:0] op, input logic [7:0] asid,
                             input logic [18:0] vpn, input logic [9:0] key,
                             input logic [3:0] drwx, input logic last,
                             input logic [63:0] rpte, input logic [63:0] rvpn,
                             output int lat);
        logic [63:0] pte;
        pte = (64'(key) << 32) + (64'(asid) << 24) + (64'(last) << 22)
            + (64'(drwx[3]) << 7) + (64'(drwx) & 64'h7);
        exp_log.delete();
        if (op == 2'b01 || op == 2'b10) begin
            exp_log.push_back('{we: 1'b1, adr: BASE + 32'd16, dat: pte});
            exp_log.push_back('{we: 1'b1, adr: BASE + 32'd24, dat: 64'(vpn)});
            exp_log.push_back('{we: 1'b1, adr: BASE, dat: (op == 2'b01) ? 64'd1 : 64'd2});
        end
        if (op == 2'b10 || op == 2'b11) begin
            exp_log.push_back('{we: 1'b0, adr: BASE + 32'd16, dat: 64'd0});
            exp_log.push_back('{we: 1'b0, adr: BASE + 32'd24, dat: 64'd0});
            m_key  = 10'((rpte >> 32) & 64'h3FF);
            m_asid = 8'((rpte >> 24) & 64'hFF);
            m_last = 1'((rpte >> 23) & 64'h1);
            m_drwx = 4'((((rpte >> 7) & 64'h1) * 8) + (rpte & 64'h7));
            m_vpn  = 19'(rvpn % 64'h80000);
        end
        if (op == 2'b00) lat = 1;
        else lat = 3 * exp_log.size() + ((op == 2'b11) ? 0 : SETTLE);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_key"},  64'(res_key_o),  64'(m_key));
        chk({tag, "_asid"}, 64'(res_asid_o), 64'(m_asid));
        chk({tag, "_last"}, 64'(res_last_o), 64'(m_last));
        chk({tag, "_drwx"}, 64'(res_drwx_o), 64'(m_drwx));
        chk({tag, "_vpn"},  64'(res_vpn_o),  64'(m_vpn));
        chk({tag, "_hit"},  64'(hit_o),      64'((m_drwx & 4'h7) != 4'h0));
    endtask

    task automatic check_bus(input string tag);
        chk({tag, "_nacc"}, 64'(bus_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++) begin
            chk({tag, "_we"},  64'(bus_log[i].we),  64'(exp_log[i].we));
            chk({tag, "_adr"}, 64'(bus_log[i].adr), 64'(exp_log[i].adr));
            chk({tag, "_dat"}, bus_log[i].dat,      exp_log[i].dat);
        end
    endtask

    // One complete request; call #1 after a clock edge with the DUT idle.
    task automatic do_req(input logic [1:0] op, input logic [7:0] asid,
                          input logic [18:0] vpn, input logic [9:0] key,
                          input logic [3:0] drwx, input logic last,
                          input logic [63:0] rpte, input logic [63:0] rvpn,
                          input bit scramble, output int lat);
        int exp_lat;
        model_req(op, asid, vpn, key, drwx, last, rpte, rvpn, exp_lat);
        bus_log.delete();
        rsp_pte = rpte; rsp_vpn = rvpn;
        req_i = 1'b1; op_i = op; asid_i = asid; vpn_i = vpn;
        key_i = key; drwx_i = drwx; last_i = last;
        @(posedge clk); #1;
        req_i = 1'b0;
        if (op != 2'b00) chk("busy_after_accept", 64'(busy_o), 64'd1);
        if (scramble) begin
            op_i = 2'($urandom); asid_i = 8'($urandom); vpn_i = 19'($urandom);
            key_i = 10'($urandom); drwx_i = 4'($urandom); last_i = 1'($urandom);
        end
        wait_done(lat);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy_at_done", 64'(busy_o), 64'd0);
        chk("err_at_done", 64'(err_o), 64'd0);
        check_results("res");
        check_bus("bus");
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  asid;
        logic [18:0] vpn;
        logic [9:0]  key;
        logic [3:0]  drwx;
        logic        last;
        logic [63:0] rpte;
        logic [63:0] rvpn;
        logic [7:0]  lat;
        logic [63:0] w0;
        logic [9:0]  e_key;
        logic [7:0]  e_asid;
        logic        e_last;
        logic [3:0]  e_drwx;
        logic [18:0] e_vpn;
        logic        e_hit;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat2;

        tbl[0] = '{op: 2'b01, asid: 8'h5A, vpn: 19'h12345, key: 10'h3FF, drwx: 4'b0111, last: 1'b1,
                   rpte: 64'd0, rvpn: 64'd0, lat: 8'd17, w0: 64'h0000_03FF_5A40_0007,
                   e_key: 10'h0, e_asid: 8'h0, e_last: 1'b0, e_drwx: 4'h0, e_vpn: 19'h0, e_hit: 1'b0};
        tbl[1] = '{op: 2'b10, asid: 8'h11, vpn: 19'h0ABCD, key: 10'h155, drwx: 4'b0000, last: 1'b0,
                   rpte: 64'h0000_0155_3C80_0006, rvpn: 64'hFFFF_0000_FFF0_ABCD, lat: 8'd23,
                   w0: 64'h0000_0155_1100_0000,
                   e_key: 10'h155, e_asid: 8'h3C, e_last: 1'b1, e_drwx: 4'b0110, e_vpn: 19'h0ABCD, e_hit: 1'b1};
        tbl[2] = '{op: 2'b01, asid: 8'hA5, vpn: 19'h7FFFF, key: 10'h000, drwx: 4'b1000, last: 1'b0,
                   rpte: 64'd0, rvpn: 64'd0, lat: 8'd17, w0: 64'h0000_0000_A500_0080,
                   e_key: 10'h155, e_asid: 8'h3C, e_last: 1'b1, e_drwx: 4'b0110, e_vpn: 19'h0ABCD, e_hit: 1'b1};
        tbl[3] = '{op: 2'b11, asid: 8'h00, vpn: 19'h0, key: 10'h0, drwx: 4'h0, last: 1'b0,
                   rpte: 64'h0000_02AA_C340_0081, rvpn: 64'h1234_5678_9AB7_FFFF, lat: 8'd6, w0: 64'd0,
                   e_key: 10'h2AA, e_asid: 8'hC3, e_last: 1'b0, e_drwx: 4'b1001, e_vpn: 19'h7FFFF, e_hit: 1'b1};
        tbl[4] = '{op: 2'b00, asid: 8'hFF, vpn: 19'h1, key: 10'h1, drwx: 4'hF, last: 1'b1,
                   rpte: 64'd0, rvpn: 64'd0, lat: 8'd1, w0: 64'd0,
                   e_key: 10'h2AA, e_asid: 8'hC3, e_last: 1'b0, e_drwx: 4'b1001, e_vpn: 19'h7FFFF, e_hit: 1'b1};
        tbl[5] = '{op: 2'b11, asid: 8'h00, vpn: 19'h0, key: 10'h0, drwx: 4'h0, last: 1'b0,
                   rpte: 64'h0000_0000_0000_0080, rvpn: 64'd0, lat: 8'd6, w0: 64'd0,
                   e_key: 10'h0, e_asid: 8'h0, e_last: 1'b0, e_drwx: 4'b1000, e_vpn: 19'h0, e_hit: 1'b0};
        tbl[6] = '{op: 2'b10, asid: 8'h01, vpn: 19'h00001, key: 10'h002, drwx: 4'b0001, last: 1'b1,
                   rpte: 64'd0, rvpn: 64'd0, lat: 8'd23, w0: 64'h0000_0002_0140_0001,
                   e_key: 10'h0, e_asid: 8'h0, e_last: 1'b0, e_drwx: 4'h0, e_vpn: 19'h0, e_hit: 1'b0};

        // Reset state
        rst = 1'b1; req_i = 1'b0; op_i = 2'b00; asid_i = 8'd0; vpn_i = 19'd0;
        key_i = 10'd0; drwx_i = 4'd0; last_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", 64'({busy_o, done_o, err_o, hit_o, cyc_o, stb_o, we_o, sel_o}), 64'd0);
        chk("rst_res", 64'({res_key_o, res_asid_o, res_last_o, res_drwx_o, res_vpn_o}), 64'd0);
        chk("rst_adr", 64'(adr_o), 64'd0);
        chk("rst_dat", dat_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            do_req(tbl[i].op, tbl[i].asid, tbl[i].vpn, tbl[i].key, tbl[i].drwx, tbl[i].last,
                   tbl[i].rpte, tbl[i].rvpn, 1'b1, lat);
            chk("tbl_lat",  64'(lat),        64'(tbl[i].lat));
            chk("tbl_key",  64'(res_key_o),  64'(tbl[i].e_key));
            chk("tbl_asid", 64'(res_asid_o), 64'(tbl[i].e_asid));
            chk("tbl_last", 64'(res_last_o), 64'(tbl[i].e_last));
            chk("tbl_drwx", 64'(res_drwx_o), 64'(tbl[i].e_drwx));
            chk("tbl_vpn",  64'(res_vpn_o),  64'(tbl[i].e_vpn));
            chk("tbl_hit",  64'(hit_o),      64'(tbl[i].e_hit));
            if (bus_log.size() > 0) chk("tbl_w0", bus_log[0].dat, tbl[i].w0);
            chk("sel_during_access", 64'(sel_bad), 64'd0);
        end

        // Reset in the middle of the VPN write
        bus_log.delete();
        req_i = 1'b1; op_i = 2'b01; asid_i = 8'h12; vpn_i = 19'h1F0F0; key_i = 10'h0AA;
        drwx_i = 4'b0101; last_i = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_cyc", 64'(cyc_o), 64'd1);
        chk("mid_adr", 64'(adr_o), 64'(BASE + 32'h18));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_ctl", 64'({busy_o, done_o, err_o, hit_o, cyc_o, stb_o, we_o, sel_o}), 64'd0);
        chk("mrst_res", 64'({res_key_o, res_asid_o, res_last_o, res_drwx_o, res_vpn_o}), 64'd0);
        chk("mrst_bus", 64'(adr_o) | dat_o, 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("mrst_hold_cyc", 64'(cyc_o), 64'd0);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_req(2'b11, 8'd0, 19'd0, 10'd0, 4'd0, 1'b0, 64'h0000_0321_7780_0004, 64'h0000_0000_0004_5678,
               1'b0, lat);

        // Back-to-back: req_i held high, second accepted in the done_o cycle
        model_req(2'b11, 8'd0, 19'd0, 10'd0, 4'd0, 1'b0, 64'h0000_0099_4200_0083, 64'h0000_0000_0001_2345, lat2);
        rsp_pte = 64'h0000_0099_4200_0083; rsp_vpn = 64'h0000_0000_0001_2345;
        bus_log.delete();
        req_i = 1'b1; op_i = 2'b11;
        @(posedge clk); #1;
        wait_done(lat);
        chk("b2b_lat1", 64'(lat), 64'(lat2));
        chk("b2b_gap_cyc", 64'(cyc_o), 64'd0);
        chk("b2b_busy_done", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        chk("b2b_accept", 64'({busy_o, cyc_o}), 64'd3);
        req_i = 1'b0;
        wait_done(lat);
        chk("b2b_lat2", 64'(lat), 64'(lat2));
        chk("b2b_nacc", 64'(bus_log.size()), 64'd4);
        check_results("b2b");

`ifdef IPT_CTL_TIMEOUT_EN
        // Responder never acks the VPN write
        stall_en = 1'b1; stall_adr = BASE + 32'h18;
        bus_log.delete();
        req_i = 1'b1; op_i = 2'b01;
        @(posedge clk); #1;
        req_i = 1'b0;
        wait_done(lat);
        chk("to_lat", 64'(lat), 64'd8);
        chk("to_err", 64'(err_o), 64'd1);
        chk("to_nacc", 64'(bus_log.size()), 64'd1);
        chk("to_cyc", 64'(cyc_o), 64'd0);
        stall_en = 1'b0;
        @(posedge clk); #1;
`endif

        // Randomized requests against the model
        for (int n = 0; n < 30; n++) begin
            do_req(2'($urandom_range(0, 3)), 8'($urandom), 19'($urandom), 10'($urandom),
                   4'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   1'b1, lat);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end
        chk("sel_total", 64'(sel_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
